uart_phy: RTL and testbench

Serial line engine sitting directly downstream of the AHB-to-UART bridge. It consumes the bridge's byte-wide tx handshake and serialises each byte onto `txd`, and deserialises `rxd` into bytes that it presents on the bridge's rx handshake. Frame format is fixed 8N1 (8E1 with parity compiled in), LSB first, with a compile-time bit period.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_phy.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_phy.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the uart_phy serial engine.
//               Optional even parity is enabled by defining UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_PARITY_EN
    // start + data + parity + stop
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 3;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } uart_tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } uart_rx_state_t;
`else
    // start + data + stop
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd4
    } uart_tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd4
    } uart_rx_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Down-counting bit timer. Loading value N makes expire assert
//               N cycles later; the count holds at zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] r_cnt;

    // Load on request, otherwise count down and saturate at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_phy.sv
`default_nettype none
// ============================================================================
// Module      : uart_phy
// Description : 8N1 UART serialiser/deserialiser behind the AHB-UART bridge.
//               Define UART_PARITY_EN for 8E1 framing (even parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int TW = $clog2(CLK_DIV);
    // A load of N expires N cycles later, so a full bit needs CLK_DIV-1
    localparam logic [TW-1:0] c_bit_reload  = TW'(CLK_DIV - 1);
    // Mid-bit offset, less one cycle for the edge-detect flop and one for the load
    localparam logic [TW-1:0] c_half_reload = TW'(CLK_DIV / 2 - 2);
    localparam logic [2:0]    c_last_bit    = 3'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------ TX
    uart_tx_state_t r_tx_state;
    logic [7:0]     r_tx_shreg;
    logic [2:0]     r_tx_idx;
    logic           r_txd;
    logic           w_tx_load;
    logic           w_tx_expire;
`ifdef UART_PARITY_EN
    logic           r_tx_par;
`endif

    assign tx_ready  = (r_tx_state == TX_IDLE);
    assign txd       = r_txd;
    assign w_tx_load = (r_tx_state == TX_IDLE) ? tx_valid : w_tx_expire;

    uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_tx_load),
        .load_val (c_bit_reload),
        .expire   (w_tx_expire)
    );

    // TX frame sequencer; txd is registered so each level lasts a full bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= TX_IDLE;
            r_tx_shreg <= 8'h00;
            r_tx_idx   <= 3'd0;
            r_txd      <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        r_tx_shreg <= tx_data;
                        r_tx_idx   <= 3'd0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^tx_data;
`endif
                    end
                end
                TX_START: begin
                    if (w_tx_expire) begin
                        r_txd      <= r_tx_shreg[0];
                        r_tx_shreg <= r_tx_shreg >> 1;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_expire) begin
                        if (r_tx_idx == c_last_bit) begin
`ifdef UART_PARITY_EN
                            r_txd      <= r_tx_par;
                            r_tx_state <= TX_PAR;
`else
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_txd      <= r_tx_shreg[0];
                            r_tx_shreg <= r_tx_shreg >> 1;
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PAR: begin
                    if (w_tx_expire) begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_tx_expire) begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic [1:0]     r_sync;
    logic           r_rxs_prev;
    logic           w_rxs;
    uart_rx_state_t r_rx_state;
    logic [7:0]     r_rx_shreg;
    logic [2:0]     r_rx_idx;
    logic           r_rx_valid;
    logic [7:0]     r_rx_data;
    logic           r_rx_frame_err;
    logic           r_rx_overrun;
    logic           w_rx_fall;
    logic           w_rx_load;
    logic [TW-1:0]  w_rx_load_val;
    logic           w_rx_expire;
    logic           w_rx_accept;
    logic           w_stop_ok;
`ifdef UART_PARITY_EN
    logic           r_rx_par_bad;
`endif

    assign w_rxs         = r_sync[1];
    assign w_rx_fall     = r_rxs_prev && !w_rxs;
    assign w_rx_accept   = r_rx_valid && rx_ready;
    assign w_rx_load     = (r_rx_state == RX_IDLE) ? w_rx_fall : w_rx_expire;
    assign w_rx_load_val = (r_rx_state == RX_IDLE) ? c_half_reload : c_bit_reload;
`ifdef UART_PARITY_EN
    assign w_stop_ok     = w_rxs && !r_rx_par_bad;
`else
    assign w_stop_ok     = w_rxs;
`endif

    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign rx_frame_err  = r_rx_frame_err;
    assign rx_overrun    = r_rx_overrun;

    uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_rx_load),
        .load_val (w_rx_load_val),
        .expire   (w_rx_expire)
    );

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync     <= 2'b11;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxs_prev <= r_sync[1];
        end
    end

    // RX frame sequencer and bridge-side handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_state     <= RX_IDLE;
            r_rx_shreg     <= 8'h00;
            r_rx_idx       <= 3'd0;
            r_rx_valid     <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad   <= 1'b0;
`endif
        end else begin
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
            if (w_rx_accept) begin
                r_rx_valid <= 1'b0;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_expire) begin
                        if (w_rxs) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_idx   <= 3'd0;
                            r_rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_expire) begin
                        r_rx_shreg <= {w_rxs, r_rx_shreg[7:1]};
                        if (r_rx_idx == c_last_bit) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PAR;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_idx <= r_rx_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PAR: begin
                    if (w_rx_expire) begin
                        r_rx_par_bad <= (w_rxs != ^r_rx_shreg);
                        r_rx_state   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_rx_expire) begin
                        r_rx_state <= RX_IDLE;
                        if (w_stop_ok) begin
                            // An accept in this cycle frees the holding slot first
                            if (!r_rx_valid || w_rx_accept) begin
                                r_rx_data  <= r_rx_shreg;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_rx_overrun <= 1'b1;
                            end
                        end else begin
                            r_rx_frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_phy.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_phy
// Description : Directed self-checking bench for uart_phy with CLK_DIV = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_phy;

    localparam int CLK_DIV = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       txd;
    logic       rxd;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;

    uart_phy #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .txd          (txd),
        .rxd          (rxd)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle status outputs
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_frame_err) fe_cnt++;
            if (rx_overrun)   ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame on rxd, each bit held CLK_DIV cycles, starting just after a posedge
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    logic [9:0] frame_a5;
    logic       tx_rec [0:199];
    int         low_cnt;
    int         fe0, ov0;
    int         f0, f1, run0, run1;
    logic       ok;
    logic       drop_next;
    logic       seen_busy;

    initial begin
        // ---------------- reset state
        rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // ---------------- single TX byte 0xA5
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1 tx_valid = 1'b0;
        low_cnt = 0;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                if (txd !== frame_a5[b]) ok = 1'b0;
                if (tx_ready === 1'b0) low_cnt++;
            end
            check($sformatf("tx_a5_bit%0d_held", b), 32'(ok), 32'd1);
        end
        @(negedge clk);
        check("tx_a5_ready_low_cycles", 32'(low_cnt), 32'd80);
        check("tx_a5_ready_after", 32'(tx_ready), 32'd1);
        check("tx_a5_txd_idle", 32'(txd), 32'd1);

        // ---------------- back-to-back TX 0x00 then 0xFF, tx_valid held high
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h00;
        drop_next = 1'b0; seen_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tx_rec[i] = txd;
            if (drop_next) begin
                tx_valid  = 1'b0;
                drop_next = 1'b0;
            end
            if (!tx_ready) seen_busy = 1'b1;
            if (i == 2) tx_data = 8'hFF;
            if (tx_ready && seen_busy && tx_valid) drop_next = 1'b1;
        end
        f0 = -1; f1 = -1; run0 = 0; run1 = 0;
        for (int i = 1; i < 200; i++) begin
            if (tx_rec[i-1] && !tx_rec[i]) begin
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
        end
        if (f0 >= 0) for (int i = f0; i < 200 && !tx_rec[i]; i++) run0++;
        if (f1 >= 0) for (int i = f1; i < 200 && !tx_rec[i]; i++) run1++;
        // Frame 1 start is one cycle after the handshake edge
        check("b2b_first_start", 32'(f0), 32'd1);
        // Start bit plus eight zero data bits
        check("b2b_first_low_run", 32'(run0), 32'd72);
        // 80-cycle frame, then the single tx_ready cycle that carries the next handshake
        check("b2b_start_spacing", 32'(f1 - f0), 32'd81);
        // Second frame: start bit only, 0xFF data is high
        check("b2b_second_low_run", 32'(run1), 32'd8);
        check("b2b_final_idle", 32'(tx_rec[199]), 32'd1);

        // ---------------- RX 0x3C with late accept
        fe0 = fe_cnt; ov0 = ov_cnt;
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        check("rx_3c_valid", 32'(rx_valid), 32'd1);
        check("rx_3c_data", 32'(rx_data), 32'h3C);
        repeat (5) @(negedge clk);
        check("rx_3c_valid_held", 32'(rx_valid), 32'd1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(negedge clk);
        check("rx_3c_valid_before_clear", 32'(rx_valid), 32'd1);
        @(negedge clk);
        check("rx_3c_valid_cleared", 32'(rx_valid), 32'd0);
        @(posedge clk); #1 rx_ready = 1'b0;
        check("rx_3c_no_err", 32'(fe_cnt - fe0), 32'd0);

        // ---------------- overrun: 0x11 then 0x22 without accept
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_pulse_count", 32'(ov_cnt - ov0), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        @(posedge clk); #1 rx_ready = 1'b1;
        repeat (2) @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_drained", 32'(rx_valid), 32'd0);

        // ---------------- framing error: stop bit low
        fe0 = fe_cnt; ov0 = ov_cnt;
        @(posedge clk); #1;
        send_frame(8'h55, 1'b0);
        repeat (3 * CLK_DIV) @(negedge clk);
        check("ferr_pulse_count", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_valid", 32'(rx_valid), 32'd0);

        // ---------------- 2-cycle glitch on rxd
        fe0 = fe_cnt; ov0 = ov_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (2) @(posedge clk); #1 rxd = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        check("glitch_no_err", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_no_overrun", 32'(ov_cnt - ov0), 32'd0);

        // ---------------- a clean byte after the glitch still decodes
        @(posedge clk); #1;
        send_frame(8'hC3, 1'b1);
        repeat (2) @(negedge clk);
        check("post_glitch_data", 32'(rx_data), 32'hC3);
        check("post_glitch_valid", 32'(rx_valid), 32'd1);

        // ---------------- reset in the middle of a TX frame (frame bit 4 = A5 bit3 = 0)
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1 tx_valid = 1'b0;
        repeat (4 * CLK_DIV + 2) @(posedge clk);
        #2;
        check("midtx_txd_bit4", 32'(txd), 32'd0);
        check("midtx_busy", 32'(tx_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("midtx_rst_txd", 32'(txd), 32'd1);
        check("midtx_rst_ready", 32'(tx_ready), 32'd1);
        check("midtx_rst_rx_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("midtx_rst_txd_held", 32'(txd), 32'd1);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("midtx_after_rst_txd", 32'(txd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
